// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues the dcache request for a latched load/store, stalls
// upstream until dhit, returns load data and latches halt. Optional watchdog: MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              halt_in,
    input  logic              flush,
    input  logic [WORD_W-1:0] port_o_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_data,
    output logic              load_valid,
    output logic              halt_out,
    output logic              misalign,
    output logic              timeout_err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:2]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                is_wr_q, is_wr_d;
    logic [WORD_W-1:0]   load_data_q, load_data_d;
    logic                req;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    assign req = (dREN_in | dWEN_in) & ~flush;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_wr_d     = is_wr_q;
        load_data_d = load_data_q;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        mem_stall   = 1'b0;
        load_valid  = 1'b0;
        halt_out    = 1'b0;
        misalign    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        terr_d      = terr_q;
`endif
        case (state_q)
            IDLE: begin
                // halt wins over a simultaneous memory op
                if (halt_in && !flush) begin
                    state_d = HALTED;
                end else if (req) begin
                    addr_d    = port_o_in[WORD_W-1:2];
                    data_d    = rdat2_in;
                    is_wr_d   = dWEN_in;
                    misalign  = |port_o_in[1:0];
                    mem_stall = 1'b1;
                    state_d   = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ACCESS: begin
                dmemWEN   = is_wr_q;
                dmemREN   = ~is_wr_q;
                mem_stall = 1'b1;
                if (dhit) begin
                    if (!is_wr_q) load_data_d = dmemload;
                    state_d = DONE;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    terr_d = 1'b1;
                    if (!is_wr_q) load_data_d = WORD_W'(32'hBAD1BAD1);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                load_valid = ~is_wr_q;
                state_d    = IDLE;
            end
            HALTED: halt_out = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            is_wr_q     <= 1'b0;
            load_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            terr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            is_wr_q     <= is_wr_d;
            load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
`endif
        end
    end

    assign dmemaddr  = {addr_q, 2'b00};
    assign dmemstore = data_q;
    assign load_data = load_data_q;
`ifdef MEM_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; covers the watchdog when built with MEM_TIMEOUT_EN.
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dREN_in = 0, dWEN_in = 0, halt_in = 0, flush = 0, dhit = 0;
    logic [31:0] port_o_in = 0, rdat2_in = 0, dmemload = 0;
    logic        dmemREN, dmemWEN, mem_stall, load_valid, halt_out, misalign, timeout_err;
    logic [31:0] dmemaddr, dmemstore, load_data;

    int checks = 0;
    int errors = 0;
    int nstall, nwen, nren;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    mem_stage_ctrl #(.WORD_W(32), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in), .flush(flush),
        .port_o_in(port_o_in), .rdat2_in(rdat2_in), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
        .halt_out(halt_out), .misalign(misalign), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_ren", {31'b0, dmemREN}, 32'd0);
        chk("rst_wen", {31'b0, dmemWEN}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_halt", {31'b0, halt_out}, 32'd0);
        chk("rst_lv", {31'b0, load_valid}, 32'd0);
        chk("rst_ldata", load_data, 32'd0);
        chk("rst_addr", dmemaddr, 32'd0);
        chk("rst_terr", {31'b0, timeout_err}, 32'd0);
        RST = 1'b0;
        step();

        // 1: load 0x100, dhit in first ACCESS cycle
        dREN_in = 1; port_o_in = 32'h100; #1;
        chk("t1_idle_stall", {31'b0, mem_stall}, 32'd1);
        chk("t1_idle_ren", {31'b0, dmemREN}, 32'd0);
        chk("t1_misalign", {31'b0, misalign}, 32'd0);
        step();
        dhit = 1; dmemload = 32'hDEADBEEF; #1;
        chk("t1_acc_ren", {31'b0, dmemREN}, 32'd1);
        chk("t1_acc_addr", dmemaddr, 32'h100);
        chk("t1_acc_stall", {31'b0, mem_stall}, 32'd1);
        step();
        dhit = 0; dREN_in = 0; #1;
        chk("t1_done_ren", {31'b0, dmemREN}, 32'd0);
        chk("t1_done_stall", {31'b0, mem_stall}, 32'd0);
        chk("t1_done_lv", {31'b0, load_valid}, 32'd1);
        chk("t1_done_data", load_data, 32'hDEADBEEF);
        step();
        chk("t1_after_lv", {31'b0, load_valid}, 32'd0);
        chk("t1_hold_data", load_data, 32'hDEADBEEF);

        // 2: store 0x204, dhit on the 4th ACCESS cycle
        dWEN_in = 1; port_o_in = 32'h204; rdat2_in = 32'h12345678; #1;
        nstall = 0; nwen = 0; nren = 0;
        for (int i = 0; i < 5; i++) begin
            dhit = (i == 4); #1;
            if (mem_stall) nstall++;
            if (dmemWEN) nwen++;
            if (dmemREN) nren++;
            if (i == 1) begin
                chk("t2_addr", dmemaddr, 32'h204);
                chk("t2_store", dmemstore, 32'h12345678);
            end
            step();
        end
        dhit = 0; dWEN_in = 0; #1;
        chk("t2_wen_cycles", nwen, 32'd4);
        chk("t2_stall_cycles", nstall, 32'd5);
        chk("t2_ren_cycles", nren, 32'd0);
        chk("t2_done_lv", {31'b0, load_valid}, 32'd0);
        chk("t2_done_stall", {31'b0, mem_stall}, 32'd0);
        chk("t2_ldata_kept", load_data, 32'hDEADBEEF);
        step();

        // 5: misaligned load, then dREN&dWEN treated as store
        dREN_in = 1; port_o_in = 32'h103; #1;
        chk("t5_misalign", {31'b0, misalign}, 32'd1);
        step();
        dhit = 1; dmemload = 32'hCAFEF00D; #1;
        chk("t5_mis_clear", {31'b0, misalign}, 32'd0);
        chk("t5_addr", dmemaddr, 32'h100);
        chk("t5_ren", {31'b0, dmemREN}, 32'd1);
        step();
        dhit = 0; dREN_in = 0; #1;
        chk("t5_ldata", load_data, 32'hCAFEF00D);
        step();
        dREN_in = 1; dWEN_in = 1; port_o_in = 32'h208; rdat2_in = 32'hA5A5A5A5;
        step();
        dhit = 1; #1;
        chk("t5_both_wen", {31'b0, dmemWEN}, 32'd1);
        chk("t5_both_ren", {31'b0, dmemREN}, 32'd0);
        chk("t5_both_store", dmemstore, 32'hA5A5A5A5);
        step();
        dhit = 0; dREN_in = 0; dWEN_in = 0; #1;
        chk("t5_both_lv", {31'b0, load_valid}, 32'd0);
        step();

        // missing dhit: watchdog fires or access waits
        dREN_in = 1; port_o_in = 32'h300;
        step();
        nren = 0;
        while (dmemREN && nren < 20) begin
            nren++;
            step();
        end
`ifdef MEM_TIMEOUT_EN
        dREN_in = 0; #1;
        chk("t6_access_cycles", nren, 32'd8);
        chk("t6_terr", {31'b0, timeout_err}, 32'd1);
        chk("t6_ldata", load_data, 32'hBAD1BAD1);
        chk("t6_lv", {31'b0, load_valid}, 32'd1);
        chk("t6_stall", {31'b0, mem_stall}, 32'd0);
        step();
        chk("t6_terr_sticky", {31'b0, timeout_err}, 32'd1);
`else
        chk("nto_wait_cycles", nren, 32'd20);
        chk("nto_stall", {31'b0, mem_stall}, 32'd1);
        chk("nto_terr", {31'b0, timeout_err}, 32'd0);
        dhit = 1; step();
        dhit = 0; dREN_in = 0; step();
`endif

        // 4: async reset mid-ACCESS
        dREN_in = 1; port_o_in = 32'h400;
        step();
        chk("t4_pre_ren", {31'b0, dmemREN}, 32'd1);
        #2 RST = 1; dREN_in = 0; #1;
        chk("t4_async_ren", {31'b0, dmemREN}, 32'd0);
        chk("t4_stall", {31'b0, mem_stall}, 32'd0);
        chk("t4_ldata", load_data, 32'd0);
        chk("t4_addr", dmemaddr, 32'd0);
        chk("t4_terr", {31'b0, timeout_err}, 32'd0);
        step();
        RST = 0;
        step();
        chk("t4_idle_ren", {31'b0, dmemREN}, 32'd0);

        // 3: flushed load, then halt
        dREN_in = 1; flush = 1; #1;
        chk("t3_flush_stall", {31'b0, mem_stall}, 32'd0);
        step();
        chk("t3_flush_ren", {31'b0, dmemREN}, 32'd0);
        dREN_in = 0; flush = 0; halt_in = 1;
        step();
        halt_in = 0; dREN_in = 1; #1;
        chk("t3_halt", {31'b0, halt_out}, 32'd1);
        chk("t3_halt_stall", {31'b0, mem_stall}, 32'd0);
        step(); step(); step();
        chk("t3_halt_sticky", {31'b0, halt_out}, 32'd1);
        chk("t3_halt_noreq", {31'b0, dmemREN}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
